// File: rtl/telemetry_arbiter.sv
// Two-channel telemetry framer: buffers one word per channel and serialises it
// to a byte-wide UART transmitter as a 5-byte checksummed frame.
module telemetry_arbiter #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         DATA_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] ch0_data_in,
  input  logic                  ch0_valid_in,
  input  logic [DATA_WIDTH-1:0] ch1_data_in,
  input  logic                  ch1_valid_in,
  output logic [7:0]            byte_out,
  output logic                  trigger_out,
  input  logic                  busy_in,
  output logic [7:0]            overrun_count_out,
  output logic                  frame_done_out
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] SEND      = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic [2:0]            r_state;
  logic                  r_pend0;
  logic                  r_pend1;
  logic [DATA_WIDTH-1:0] r_hold0;
  logic [DATA_WIDTH-1:0] r_hold1;
  logic [15:0]           r_frameData;
  logic                  r_frameCh;
  logic [2:0]            r_idx;
  logic                  r_rrPtr;
  logic [1:0]            r_waitCnt;
  logic [7:0]            r_byteOut;
  logic                  r_frameDone;
  logic [7:0]            r_overrun;

  logic                  w_selCh;
  logic [DATA_WIDTH-1:0] w_selData;
  logic                  w_load0;
  logic                  w_load1;
  logic                  w_ovr0;
  logic                  w_ovr1;
  logic [1:0]            w_ovrInc;
  logic [8:0]            w_ovrSum;
  logic [7:0]            w_byte;
  logic                  w_trigger;

  // Round-robin pointer names the channel that wins when both are pending.
  always_comb begin
    w_selCh = r_pend1;
    if (r_pend0 && r_pend1) begin
      w_selCh = r_rrPtr;
    end
  end

  assign w_selData = w_selCh ? r_hold1 : r_hold0;
  assign w_load0   = (r_state == LOAD) && !w_selCh;
  assign w_load1   = (r_state == LOAD) && w_selCh;

  // A strobe landing on the word being loaded re-arms pending; not an overrun.
  assign w_ovr0   = ch0_valid_in && r_pend0 && !w_load0;
  assign w_ovr1   = ch1_valid_in && r_pend1 && !w_load1;
  assign w_ovrInc = {1'b0, w_ovr0} + {1'b0, w_ovr1};
  assign w_ovrSum = {1'b0, r_overrun} + {7'b0, w_ovrInc};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_hold0 <= '0;
      r_hold1 <= '0;
    end else begin
      if (ch0_valid_in) begin
        r_hold0 <= ch0_data_in;
        r_pend0 <= 1'b1;
      end else if (w_load0) begin
        r_pend0 <= 1'b0;
      end
      if (ch1_valid_in) begin
        r_hold1 <= ch1_data_in;
        r_pend1 <= 1'b1;
      end else if (w_load1) begin
        r_pend1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_overrun <= 8'h00;
    end else if (w_ovrSum[8]) begin
      r_overrun <= 8'hFF;
    end else begin
      r_overrun <= w_ovrSum[7:0];
    end
  end

  always_comb begin
    w_byte = {7'b0, r_frameCh} ^ r_frameData[15:8] ^ r_frameData[7:0];
    case (r_idx)
      3'd0:    w_byte = SYNC_BYTE;
      3'd1:    w_byte = {7'b0, r_frameCh};
      3'd2:    w_byte = r_frameData[15:8];
      3'd3:    w_byte = r_frameData[7:0];
      default: w_byte = {7'b0, r_frameCh} ^ r_frameData[15:8] ^ r_frameData[7:0];
    endcase
  end

  // Trigger fires in the SEND cycle itself; the byte is latched so it stays put
  // until the next trigger.
  assign w_trigger = (r_state == SEND) && !busy_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_frameData <= 16'h0000;
      r_frameCh   <= 1'b0;
      r_idx       <= 3'd0;
      r_rrPtr     <= 1'b0;
      r_waitCnt   <= 2'd0;
      r_byteOut   <= 8'h00;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pend0 || r_pend1) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_frameData <= 16'(w_selData);
          r_frameCh   <= w_selCh;
          r_rrPtr     <= ~w_selCh;
          r_idx       <= 3'd0;
          r_state     <= SEND;
        end
        SEND: begin
          if (w_trigger) begin
            r_byteOut <= w_byte;
            r_waitCnt <= 2'd0;
            r_state   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // A transmitter that never raises busy is assumed to take the byte.
          if (busy_in || (r_waitCnt == 2'd3)) begin
            r_state <= WAIT_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + 2'd1;
          end
        end
        WAIT_IDLE: begin
          if (!busy_in) begin
            if (r_idx == 3'd4) begin
              r_frameDone <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= SEND;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trigger_out       = w_trigger;
  assign byte_out          = w_trigger ? w_byte : r_byteOut;
  assign frame_done_out    = r_frameDone;
  assign overrun_count_out = r_overrun;

endmodule

// File: tb/tb_telemetry_arbiter.sv
// Directed self-checking bench for telemetry_arbiter with a simple UART busy model.
module tb_telemetry_arbiter;

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic [15:0] ch0Data;
  logic        ch0Valid;
  logic [15:0] ch1Data;
  logic        ch1Valid;
  logic [7:0]  byteOut;
  logic        triggerOut;
  logic        busyIn;
  logic        busyHold;
  logic        busyModel;
  logic [7:0]  overrunCount;
  logic        frameDone;

  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  int          frameDoneCount = 0;
  int          strobeCycle = 0;
  bit          uartMode = 1'b1;
  logic [7:0]  byteLog[$];
  int          trigCycle[$];

  always #5 clkIn = ~clkIn;

  assign busyIn = busyHold | busyModel;

  telemetry_arbiter dut (
    .clk_in            (clkIn),
    .rst_in            (rstIn),
    .ch0_data_in       (ch0Data),
    .ch0_valid_in      (ch0Valid),
    .ch1_data_in       (ch1Data),
    .ch1_valid_in      (ch1Valid),
    .byte_out          (byteOut),
    .trigger_out       (triggerOut),
    .busy_in           (busyIn),
    .overrun_count_out (overrunCount),
    .frame_done_out    (frameDone)
  );

  always @(posedge clkIn) cycleCount++;

  always @(negedge clkIn) begin
    if (frameDone === 1'b1) frameDoneCount++;
  end

  // UART model: logs each triggered byte, then stays busy for 10 cycles.
  initial begin
    busyModel = 1'b0;
    forever begin
      @(negedge clkIn);
      if (triggerOut === 1'b1) begin
        byteLog.push_back(byteOut);
        trigCycle.push_back(cycleCount);
        if (uartMode) begin
          @(posedge clkIn);
          #1 busyModel = 1'b1;
          repeat (10) @(posedge clkIn);
          #1 busyModel = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit en0, input bit en1,
                               input logic [15:0] d0, input logic [15:0] d1);
    @(negedge clkIn);
    ch0Valid    = en0;
    ch1Valid    = en1;
    ch0Data     = d0;
    ch1Data     = d1;
    strobeCycle = cycleCount;
    @(negedge clkIn);
    ch0Valid = 1'b0;
    ch1Valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clkIn);
    rstIn = 1'b1;
    repeat (12) @(negedge clkIn);
    byteLog.delete();
    trigCycle.delete();
    frameDoneCount = 0;
    rstIn = 1'b0;
  endtask

  task automatic waitFrames(input string tag, input int n);
    for (int c = 0; c < 400 && frameDoneCount < n; c++) @(negedge clkIn);
    checkOutput({tag, " frames"}, frameDoneCount, n);
  endtask

  task automatic checkFrame(input string tag, input int start, input logic [39:0] exp);
    logic [31:0] obs;
    for (int i = 0; i < 5; i++) begin
      obs = (start + i < byteLog.size()) ? {24'h0, byteLog[start + i]} : 32'hDEAD;
      checkOutput($sformatf("%s byte%0d", tag, i), obs, {24'h0, exp[39 - 8*i -: 8]});
    end
  endtask

  initial begin
    rstIn    = 1'b1;
    ch0Valid = 1'b0;
    ch1Valid = 1'b0;
    ch0Data  = 16'h0;
    ch1Data  = 16'h0;
    busyHold = 1'b0;
    repeat (3) @(negedge clkIn);
    checkOutput("reset byte_out", {24'h0, byteOut}, 32'h0);
    checkOutput("reset trigger", {31'h0, triggerOut}, 32'h0);
    checkOutput("reset frame_done", {31'h0, frameDone}, 32'h0);
    checkOutput("reset overrun", {24'h0, overrunCount}, 32'h0);
    doReset();

    $display("[TB] single word");
    applyStimulus(1'b1, 1'b0, 16'h0123, 16'h0);
    waitFrames("single", 1);
    checkFrame("single", 0, 40'hA5_00_01_23_22);
    checkOutput("single latency", trigCycle.size() > 0 ? trigCycle[0] - strobeCycle : -1, 3);
    repeat (30) @(negedge clkIn);
    checkOutput("single done once", frameDoneCount, 1);
    checkOutput("single byte count", byteLog.size(), 5);
    checkOutput("single byte_out hold", {24'h0, byteOut}, 32'h22);
    doReset();

    $display("[TB] simultaneous strobes");
    applyStimulus(1'b1, 1'b1, 16'h0010, 16'h8001);
    waitFrames("simul", 2);
    checkFrame("simul ch0", 0, 40'hA5_00_00_10_10);
    checkFrame("simul ch1", 5, 40'hA5_01_80_01_80);
    checkOutput("simul overrun", {24'h0, overrunCount}, 32'h0);
    doReset();

    $display("[TB] overrun");
    applyStimulus(1'b1, 1'b0, 16'h0042, 16'h0);
    repeat (20) @(negedge clkIn);
    applyStimulus(1'b0, 1'b1, 16'h0, 16'h0001);
    applyStimulus(1'b0, 1'b1, 16'h0, 16'h0002);
    applyStimulus(1'b0, 1'b1, 16'h0, 16'h0003);
    checkOutput("ovr count mid", {24'h0, overrunCount}, 32'h2);
    waitFrames("ovr", 2);
    checkFrame("ovr ch0", 0, 40'hA5_00_00_42_42);
    checkFrame("ovr ch1", 5, 40'hA5_01_00_03_02);
    checkOutput("ovr byte count", byteLog.size(), 10);
    checkOutput("ovr count end", {24'h0, overrunCount}, 32'h2);
    doReset();

    $display("[TB] saturation");
    busyHold = 1'b1;
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 16'h0, 16'(i));
    checkOutput("sat count", {24'h0, overrunCount}, 32'hFF);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 16'h0, 16'(i));
    checkOutput("sat stays", {24'h0, overrunCount}, 32'hFF);
    checkOutput("sat no trigger", byteLog.size(), 0);
    busyHold = 1'b0;
    doReset();

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 16'h0123, 16'h0);
    for (int c = 0; c < 400 && byteLog.size() < 3; c++) @(negedge clkIn);
    checkOutput("rst bytes before", byteLog.size(), 3);
    repeat (2) @(negedge clkIn);
    rstIn    = 1'b1;
    ch0Valid = 1'b1;
    ch1Valid = 1'b1;
    #1;
    checkOutput("rst byte_out", {24'h0, byteOut}, 32'h0);
    checkOutput("rst trigger", {31'h0, triggerOut}, 32'h0);
    checkOutput("rst frame_done", {31'h0, frameDone}, 32'h0);
    repeat (12) @(negedge clkIn);
    ch0Valid = 1'b0;
    ch1Valid = 1'b0;
    frameDoneCount = 0;
    rstIn = 1'b0;
    repeat (40) @(negedge clkIn);
    checkOutput("rst no resume", byteLog.size(), 3);
    checkOutput("rst overrun", {24'h0, overrunCount}, 32'h0);
    applyStimulus(1'b0, 1'b1, 16'h0, 16'h00FF);
    waitFrames("rst next", 1);
    checkFrame("rst next", 3, 40'hA5_01_00_FF_FE);
    doReset();

    $display("[TB] missing busy");
    uartMode = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'hBEEF, 16'h0);
    waitFrames("nobusy", 1);
    checkFrame("nobusy", 0, 40'hA5_00_BE_EF_51);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("nobusy gap%0d", i),
                  (i + 1 < trigCycle.size()) ? trigCycle[i+1] - trigCycle[i] : -1, 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
